coproc_rf_bridge: RTL and testbench
===================================

# coproc_rf_bridge

Register-file access bridge between `square_matrix_mult` and `register_file`. It arbitrates between a host port, which loads matrices A/B and reads back C, and the coprocessor's read/write request port. It launches the coprocessor and reports completion. All register-file and coprocessor transactions go through this block's FSM.

## Interface
- `size`, 2, matrix dimension
- `cell_width`, 32, bits per cell; row bus `width = size*cell_width`
- `address_width`, `$clog2(size*size)`, register-file address width
- `in_clk` in 1: clock, rising edge
- `in_reset` in 1: asynchronous, active-high reset
- `in_host_valid` in 1: host request, held until `out_host_ack`
- `in_host_write` in 1: 1 = write, 0 = read
- `in_host_address` in `address_width`; `in_host_type` in 2; `in_host_matrix` in 2 (A=00, B=01, C=10)
- `in_host_data` in `width`: host write data
- `out_host_ack` out 1: one-cycle completion pulse
- `out_host_data` out `width`: read data, valid while `out_host_ack`=1
- `in_start` in 1: level request to run the coprocessor
- `out_done` out 1: run finished; held until `in_start`=0
- `out_cop_start` out 1: drives coprocessor `in_ready`
- `in_cop_ready` in 1: coprocessor `out_ready`
- `in_cop_read_en`, `in_cop_write_en` in 1; `in_cop_address` in `address_width`; `in_cop_type`, `in_cop_matrix` in 2; `in_cop_data` in `width` (`out_cell_c`)
- `out_cop_data` out `width`; `out_cop_data_ready` out 1 (one-cycle pulse); `out_cop_ack` out 1 (write-done pulse)
- `out_rf_address`, `out_rf_type`, `out_rf_matrix`, `out_rf_data`, `out_rf_read_en`, `out_rf_write_en` out: register-file request
- `in_rf_data` in `width`: register-file `out_data`

## Operation
- FSM states: IDLE, HOST_WR, HOST_RD, HOST_RD_WAIT, RUN, COP_RD, COP_RD_WAIT, COP_WR, DONE.
- IDLE transitions:
  - `in_host_valid` → HOST_WR or HOST_RD. Host wins if `in_start` is asserted in the same cycle.
  - Otherwise `in_start` → RUN.
- RUN:
  - `out_cop_start`=1 throughout.
  - Request priority: read, then write, then `in_cop_ready`.
  - `in_cop_ready` with no request pending → DONE.
- Host requests arriving outside IDLE are held (no ack) until the FSM returns to IDLE.
- Coprocessor requests are level-held.
  - The bridge ignores requests in any cycle where its own `out_cop_ack` or `out_cop_data_ready` is 1, so one request is never serviced twice.
  - Read+write asserted together: read is served first; the write is served next if still asserted.
- DONE: `out_done`=1 and `out_cop_start`=0. Returns to IDLE when `in_start`=0.
- All outputs are registered.
- Register-file `out_rf_data` carries `in_host_data` or `in_cop_data` unmodified, full row width.

## Timing
- Reset (async, immediate): state IDLE; every output 0, including buses. An in-flight `out_rf_write_en` drops immediately and the write is aborted.
- Write latency (edge E samples the request):
  - Cycle after E: `out_rf_write_en`=1 plus address/type/matrix/data, and the ack pulse (`out_host_ack` or `out_cop_ack`) for exactly one cycle.
  - Then return to IDLE/RUN.
- Read latency:
  - After E: `out_rf_read_en`=1 for one cycle (HOST_RD/COP_RD).
  - Register-file data is valid in the following cycle (\*_RD_WAIT) and is registered at the next edge.
  - `out_host_data`/`out_cop_data` plus the ack/data_ready pulse appear 3 cycles after E, for one cycle.
  - Read data output holds its value until the next read.
- `out_rf_*_en` are never both 1. Request fields are 0 whenever neither enable is 1.
- Back-to-back: a new request is accepted at the edge ending the ack cycle at the earliest, i.e. one idle cycle between services.

## Structure
- Shared package:
  - matrix select constants `MAT_A`=00, `MAT_B`=01, `MAT_C`=10.
  - access type constants (`TYPE_ROW`=01).
  - FSM state enum.
- One sub-module, `rf_req_reg`: register group holding the six register-file request outputs, loaded from a host/coprocessor mux, with a synchronous clear.
- Target size: about 200 RTL lines.

## Test plan
- **Reset:** assert `in_reset` mid-HOST_WR → `out_rf_write_en` and all outputs 0 within the same cycle; FSM in IDLE after release.
- **Host load and read-back:** write A row 0 = 64'h00000002_00000001, address 0, type 01 → ack 1 cycle after the sample edge. Read back the same location → `out_host_data`=64'h00000002_00000001 with ack 3 cycles after the sample edge.
- **Run:** preload A, B (2×2 identity and 2/3/4/5), pulse `in_start` with a behavioral coprocessor model → C rows read back 64'h00000003_00000002 and 64'h00000005_00000004; `out_done` held until `in_start`=0.
- **Arbitration:** `in_host_valid` and `in_start` asserted in the same cycle → host served first, then RUN. Host request during RUN → no ack until after DONE.
- **Coprocessor read+write:** read and write asserted together → read first, then write. Each is serviced exactly once; `out_rf_read_en` and `out_rf_write_en` are never both 1.
- **Back-to-back:** coprocessor holds `in_cop_read_en` for 6 cycles at address 2 → exactly two reads, separated by the ignore cycle.

Source files
------------

// File: rtl/coproc_rf_bridge_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// coproc_rf_bridge_pkg : matrix/type select codes and bridge FSM states
// Rev 1.0
// ----------------------------------------------------------------------
package coproc_rf_bridge_pkg;

  localparam logic [1:0] MAT_A = 2'b00;
  localparam logic [1:0] MAT_B = 2'b01;
  localparam logic [1:0] MAT_C = 2'b10;

  localparam logic [1:0] TYPE_CELL = 2'b00;
  localparam logic [1:0] TYPE_ROW  = 2'b01;
  localparam logic [1:0] TYPE_COL  = 2'b10;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    HOST_WR      = 4'd1,
    HOST_RD      = 4'd2,
    HOST_RD_WAIT = 4'd3,
    RUN          = 4'd4,
    COP_RD       = 4'd5,
    COP_RD_WAIT  = 4'd6,
    COP_WR       = 4'd7,
    DONE         = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/coproc_rf_bridge_rf_req_reg.sv
`default_nettype none
// ----------------------------------------------------------------------
// rf_req_reg : registered register-file request, host/coprocessor mux
// Rev 1.0
// ----------------------------------------------------------------------
module rf_req_reg #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int WIDTH         = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_load,
  input  logic                     i_sel_cop,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [1:0]               i_host_type,
  input  logic [1:0]               i_host_matrix,
  input  logic [WIDTH-1:0]         i_host_data,
  input  logic [ADDRESS_WIDTH-1:0] i_cop_address,
  input  logic [1:0]               i_cop_type,
  input  logic [1:0]               i_cop_matrix,
  input  logic [WIDTH-1:0]         i_cop_data,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [1:0]               o_type,
  output logic [1:0]               o_matrix,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_read_en,
  output logic                     o_write_en
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_address  <= '0;
      o_type     <= '0;
      o_matrix   <= '0;
      o_data     <= '0;
      o_read_en  <= 1'b0;
      o_write_en <= 1'b0;
    end else if (i_clear) begin
      o_address  <= '0;
      o_type     <= '0;
      o_matrix   <= '0;
      o_data     <= '0;
      o_read_en  <= 1'b0;
      o_write_en <= 1'b0;
    end else if (i_load) begin
      o_address  <= i_sel_cop ? i_cop_address : i_host_address;
      o_type     <= i_sel_cop ? i_cop_type    : i_host_type;
      o_matrix   <= i_sel_cop ? i_cop_matrix  : i_host_matrix;
      // Data only travels with writes so an idle/read request bus stays quiet.
      o_data     <= i_write ? (i_sel_cop ? i_cop_data : i_host_data) : '0;
      o_read_en  <= i_read & ~i_write;
      o_write_en <= i_write;
    end
  end

endmodule
`default_nettype wire

// File: rtl/coproc_rf_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------
// coproc_rf_bridge : arbitrates host and coprocessor register-file access
// Rev 1.0
// ----------------------------------------------------------------------
module coproc_rf_bridge
  import coproc_rf_bridge_pkg::*;
#(
  parameter  int size          = 2,
  parameter  int cell_width    = 32,
  parameter  int address_width = $clog2(size*size),
  localparam int width         = size*cell_width
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_host_valid,
  input  logic                     in_host_write,
  input  logic [address_width-1:0] in_host_address,
  input  logic [1:0]               in_host_type,
  input  logic [1:0]               in_host_matrix,
  input  logic [width-1:0]         in_host_data,
  output logic                     out_host_ack,
  output logic [width-1:0]         out_host_data,
  input  logic                     in_start,
  output logic                     out_done,
  output logic                     out_cop_start,
  input  logic                     in_cop_ready,
  input  logic                     in_cop_read_en,
  input  logic                     in_cop_write_en,
  input  logic [address_width-1:0] in_cop_address,
  input  logic [1:0]               in_cop_type,
  input  logic [1:0]               in_cop_matrix,
  input  logic [width-1:0]         in_cop_data,
  output logic [width-1:0]         out_cop_data,
  output logic                     out_cop_data_ready,
  output logic                     out_cop_ack,
  output logic [address_width-1:0] out_rf_address,
  output logic [1:0]               out_rf_type,
  output logic [1:0]               out_rf_matrix,
  output logic [width-1:0]         out_rf_data,
  output logic                     out_rf_read_en,
  output logic                     out_rf_write_en,
  input  logic [width-1:0]         in_rf_data
);

  state_t r_state;

  // A request still visible during its own completion pulse is the one just served.
  logic w_host_req;
  logic w_cop_rd;
  logic w_cop_wr;
  assign w_host_req = in_host_valid & ~out_host_ack;
  assign w_cop_rd   = in_cop_read_en  & ~(out_cop_ack | out_cop_data_ready);
  assign w_cop_wr   = in_cop_write_en & ~(out_cop_ack | out_cop_data_ready);

  logic w_load;
  logic w_clear;
  logic w_sel_cop;
  logic w_read;
  logic w_write;

  always_comb begin
    w_load    = 1'b0;
    w_clear   = 1'b0;
    w_sel_cop = 1'b0;
    w_read    = 1'b0;
    w_write   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_host_req) begin
          w_load  = 1'b1;
          w_read  = ~in_host_write;
          w_write = in_host_write;
        end
      end
      RUN: begin
        if (w_cop_rd) begin
          w_load    = 1'b1;
          w_sel_cop = 1'b1;
          w_read    = 1'b1;
        end else if (w_cop_wr) begin
          w_load    = 1'b1;
          w_sel_cop = 1'b1;
          w_write   = 1'b1;
        end
      end
      HOST_WR, HOST_RD, COP_RD, COP_WR: w_clear = 1'b1;
      default: ;
    endcase
  end

  rf_req_reg #(
    .ADDRESS_WIDTH (address_width),
    .WIDTH         (width)
  ) u_rf_req_reg (
    .clk            (in_clk),
    .rst            (in_reset),
    .i_clear        (w_clear),
    .i_load         (w_load),
    .i_sel_cop      (w_sel_cop),
    .i_read         (w_read),
    .i_write        (w_write),
    .i_host_address (in_host_address),
    .i_host_type    (in_host_type),
    .i_host_matrix  (in_host_matrix),
    .i_host_data    (in_host_data),
    .i_cop_address  (in_cop_address),
    .i_cop_type     (in_cop_type),
    .i_cop_matrix   (in_cop_matrix),
    .i_cop_data     (in_cop_data),
    .o_address      (out_rf_address),
    .o_type         (out_rf_type),
    .o_matrix       (out_rf_matrix),
    .o_data         (out_rf_data),
    .o_read_en      (out_rf_read_en),
    .o_write_en     (out_rf_write_en)
  );

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state            <= IDLE;
      out_host_ack       <= 1'b0;
      out_host_data      <= '0;
      out_done           <= 1'b0;
      out_cop_start      <= 1'b0;
      out_cop_data       <= '0;
      out_cop_data_ready <= 1'b0;
      out_cop_ack        <= 1'b0;
    end else begin
      out_host_ack       <= 1'b0;
      out_cop_ack        <= 1'b0;
      out_cop_data_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_host_req) begin
            r_state      <= in_host_write ? HOST_WR : HOST_RD;
            out_host_ack <= in_host_write;
          end else if (in_start) begin
            r_state       <= RUN;
            out_cop_start <= 1'b1;
          end
        end
        HOST_WR: r_state <= IDLE;
        HOST_RD: r_state <= HOST_RD_WAIT;
        HOST_RD_WAIT: begin
          out_host_data <= in_rf_data;
          out_host_ack  <= 1'b1;
          r_state       <= IDLE;
        end
        RUN: begin
          if (w_cop_rd) begin
            r_state <= COP_RD;
          end else if (w_cop_wr) begin
            r_state     <= COP_WR;
            out_cop_ack <= 1'b1;
          end else if (in_cop_ready) begin
            r_state       <= DONE;
            out_cop_start <= 1'b0;
            out_done      <= 1'b1;
          end
        end
        COP_RD: r_state <= COP_RD_WAIT;
        COP_RD_WAIT: begin
          out_cop_data       <= in_rf_data;
          out_cop_data_ready <= 1'b1;
          r_state            <= RUN;
        end
        COP_WR: r_state <= RUN;
        DONE: begin
          if (!in_start) begin
            out_done <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coproc_rf_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_coproc_rf_bridge : scoreboard bench with register-file and coprocessor models
// Rev 1.0
// ----------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coproc_rf_bridge;
  import coproc_rf_bridge_pkg::*;

  localparam int W  = 64;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_host_valid, in_host_write;
  logic [AW-1:0] in_host_address;
  logic [1:0]    in_host_type, in_host_matrix;
  logic [W-1:0]  in_host_data;
  logic          out_host_ack;
  logic [W-1:0]  out_host_data;
  logic          in_start, out_done, out_cop_start, in_cop_ready;
  logic          in_cop_read_en, in_cop_write_en;
  logic [AW-1:0] in_cop_address;
  logic [1:0]    in_cop_type, in_cop_matrix;
  logic [W-1:0]  in_cop_data;
  logic [W-1:0]  out_cop_data;
  logic          out_cop_data_ready, out_cop_ack;
  logic [AW-1:0] out_rf_address;
  logic [1:0]    out_rf_type, out_rf_matrix;
  logic [W-1:0]  out_rf_data;
  logic          out_rf_read_en, out_rf_write_en;
  logic [W-1:0]  in_rf_data;

  coproc_rf_bridge #(.size(2), .cell_width(32)) dut (
    .in_clk(clk), .in_reset(rst),
    .in_host_valid(in_host_valid), .in_host_write(in_host_write),
    .in_host_address(in_host_address), .in_host_type(in_host_type),
    .in_host_matrix(in_host_matrix), .in_host_data(in_host_data),
    .out_host_ack(out_host_ack), .out_host_data(out_host_data),
    .in_start(in_start), .out_done(out_done), .out_cop_start(out_cop_start),
    .in_cop_ready(in_cop_ready), .in_cop_read_en(in_cop_read_en),
    .in_cop_write_en(in_cop_write_en), .in_cop_address(in_cop_address),
    .in_cop_type(in_cop_type), .in_cop_matrix(in_cop_matrix), .in_cop_data(in_cop_data),
    .out_cop_data(out_cop_data), .out_cop_data_ready(out_cop_data_ready),
    .out_cop_ack(out_cop_ack), .out_rf_address(out_rf_address),
    .out_rf_type(out_rf_type), .out_rf_matrix(out_rf_matrix), .out_rf_data(out_rf_data),
    .out_rf_read_en(out_rf_read_en), .out_rf_write_en(out_rf_write_en),
    .in_rf_data(in_rf_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  typedef struct { bit rd; logic [63:0] d; } hexp_t;
  hexp_t        host_q[$];
  logic [63:0]  cop_q[$];

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Register file: read data appears the cycle after the read request.
  logic [W-1:0] mem [0:15];
  initial begin
    logic re, we;
    logic [3:0] idx;
    logic [W-1:0] d;
    in_rf_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      re = out_rf_read_en; we = out_rf_write_en;
      idx = {out_rf_matrix, out_rf_address}; d = out_rf_data;
      @(posedge clk); #1;
      if (we && !rst) mem[idx] = d;
      if (re && !rst) in_rf_data = mem[idx];
    end
  end

  int rd_cnt = 0, wr_cnt = 0, dr_cnt = 0, cack_cnt = 0, hack_cnt = 0;
  int last_dr = 0, dr_gap = 0;
  initial begin
    hexp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rf_en_excl", out_rf_read_en & out_rf_write_en, 0);
        if (!out_rf_read_en && !out_rf_write_en)
          check("rf_idle_fields", |{out_rf_address, out_rf_type, out_rf_matrix, out_rf_data}, 0);
        if (out_rf_read_en)  rd_cnt++;
        if (out_rf_write_en) wr_cnt++;
        if (out_cop_ack)     cack_cnt++;
        if (out_cop_data_ready) begin
          dr_cnt++;
          dr_gap  = cyc - last_dr;
          last_dr = cyc;
          if (cop_q.size() == 0) check("cop_rd_extra", 1, 0);
          else check("cop_rd_data", out_cop_data, cop_q.pop_front());
        end
        if (out_host_ack) begin
          hack_cnt++;
          if (host_q.size() == 0) check("host_ack_extra", 1, 0);
          else begin
            e = host_q.pop_front();
            if (e.rd) check("host_rd_data", out_host_data, e.d);
          end
        end
      end
    end
  end

  task automatic host_req(input bit wr, input logic [1:0] mat, input logic [AW-1:0] addr,
                          input logic [63:0] data, input int exp_lat, input string tag);
    int n;
    hexp_t e;
    @(posedge clk); #1;
    in_host_valid = 1; in_host_write = wr; in_host_address = addr;
    in_host_type = TYPE_ROW; in_host_matrix = mat; in_host_data = data;
    e.rd = !wr; e.d = data;
    host_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_host_ack && n < 60);
    if (!out_host_ack) check({tag, "_timeout"}, 0, 1);
    else begin
      if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
      if (wr) begin
        check({tag, "_rfreq"}, {out_rf_write_en, out_rf_read_en, out_rf_matrix, out_rf_address, out_rf_type},
              {1'b1, 1'b0, mat, addr, TYPE_ROW});
        check({tag, "_rfdata"}, out_rf_data, data);
      end
    end
    @(posedge clk); #1;
    in_host_valid = 0; in_host_write = 0; in_host_data = '0;
  endtask

  task automatic wait_sig(input string tag, input int which);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!((which == 0) ? out_cop_start : out_done) && n < 40);
    check(tag, (which == 0) ? out_cop_start : out_done, 1);
  endtask

  task automatic cop_read(input logic [1:0] mat, input logic [AW-1:0] addr,
                          input logic [63:0] exp, output logic [63:0] got);
    int n = 0;
    @(posedge clk); #1;
    in_cop_read_en = 1; in_cop_matrix = mat; in_cop_address = addr; in_cop_type = TYPE_ROW;
    cop_q.push_back(exp);
    do begin @(negedge clk); n++; end while (!out_cop_data_ready && n < 40);
    if (!out_cop_data_ready) check("cop_rd_timeout", 0, 1);
    else check("cop_rd_lat", n, 4);
    got = out_cop_data;
    @(posedge clk); #1;
    in_cop_read_en = 0;
  endtask

  task automatic cop_write(input logic [1:0] mat, input logic [AW-1:0] addr, input logic [63:0] data);
    int n = 0;
    @(posedge clk); #1;
    in_cop_write_en = 1; in_cop_matrix = mat; in_cop_address = addr;
    in_cop_type = TYPE_ROW; in_cop_data = data;
    do begin @(negedge clk); n++; end while (!out_cop_ack && n < 40);
    if (!out_cop_ack) check("cop_wr_timeout", 0, 1);
    else check("cop_wr_rfdata", {out_rf_write_en, out_rf_matrix, out_rf_address, out_rf_data[31:0]},
               {1'b1, mat, addr, data[31:0]});
    @(posedge clk); #1;
    in_cop_write_en = 0;
  endtask

  task automatic finish_run();
    @(posedge clk); #1; in_cop_ready = 1;
    wait_sig("done_rise", 1);
    check("cop_start_in_done", out_cop_start, 0);
    @(posedge clk); #1; in_cop_ready = 0; in_start = 0;
    repeat (2) @(negedge clk);
    check("done_fall", out_done, 0);
  endtask

  localparam logic [63:0] A0 = 64'h00000000_00000001, A1 = 64'h00000001_00000000;
  localparam logic [63:0] B0 = 64'h00000003_00000002, B1 = 64'h00000005_00000004;
  localparam logic [63:0] A2 = 64'h12345678_9abcdef0;

  initial begin
    logic [63:0] a [0:1];
    logic [63:0] b [0:1];
    logic [63:0] c [0:1];
    logic [31:0] s;
    int h0, rd0, wr0, dr0, ca0, n;
    bit got_dr, got_ack, order_ok;

    rst = 0; in_host_valid = 0; in_host_write = 0; in_host_address = '0; in_host_type = '0;
    in_host_matrix = '0; in_host_data = '0; in_start = 0; in_cop_ready = 0;
    in_cop_read_en = 0; in_cop_write_en = 0; in_cop_address = '0; in_cop_type = '0;
    in_cop_matrix = '0; in_cop_data = '0;
    #1 rst = 1;
    #2;
    check("rst_outputs", |{out_host_ack, out_host_data, out_done, out_cop_start, out_cop_data,
          out_cop_data_ready, out_cop_ack, out_rf_address, out_rf_type, out_rf_matrix,
          out_rf_data, out_rf_read_en, out_rf_write_en}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset in the middle of a host write aborts it at once.
    @(posedge clk); #1;
    in_host_valid = 1; in_host_write = 1; in_host_matrix = MAT_A; in_host_address = 2'd1;
    in_host_type = TYPE_ROW; in_host_data = 64'hdeadbeef_cafef00d;
    host_q.push_back('{1'b0, 64'h0});
    n = 0;
    do begin @(negedge clk); n++; end while (!out_rf_write_en && n < 20);
    check("rst_mid_wr_seen", out_rf_write_en, 1);
    #2 rst = 1;
    #1;
    check("rst_mid_wr_en", out_rf_write_en, 0);
    check("rst_mid_outs", |{out_host_ack, out_rf_data, out_rf_address, out_rf_matrix, out_rf_type}, 0);
    in_host_valid = 0; in_host_write = 0; in_host_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    host_req(1, MAT_A, 2'd0, 64'h00000002_00000001, 2, "hwr_a0");
    host_req(0, MAT_A, 2'd0, 64'h00000002_00000001, 4, "hrd_a0");
    host_req(1, MAT_A, 2'd0, A0, 2, "hwr_id0");
    host_req(1, MAT_A, 2'd1, A1, 2, "hwr_id1");
    host_req(1, MAT_B, 2'd0, B0, 2, "hwr_b0");
    host_req(1, MAT_B, 2'd1, B1, 2, "hwr_b1");
    host_req(1, MAT_A, 2'd2, A2, 2, "hwr_a2");

    // Full run with a behavioural row-oriented multiplier.
    @(posedge clk); #1; in_start = 1;
    wait_sig("cop_start_rise", 0);
    cop_read(MAT_A, 2'd0, A0, a[0]);
    cop_read(MAT_A, 2'd1, A1, a[1]);
    cop_read(MAT_B, 2'd0, B0, b[0]);
    cop_read(MAT_B, 2'd1, B1, b[1]);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = '0;
        for (int k = 0; k < 2; k++) s += a[i][k*32 +: 32] * b[k][j*32 +: 32];
        c[i][j*32 +: 32] = s;
      end
    cop_write(MAT_C, 2'd0, c[0]);
    cop_write(MAT_C, 2'd1, c[1]);
    @(posedge clk); #1; in_cop_ready = 1;
    wait_sig("done_rise_run", 1);
    @(posedge clk); #1; in_cop_ready = 0;
    repeat (3) @(negedge clk);
    check("done_held", out_done, 1);
    @(posedge clk); #1; in_start = 0;
    repeat (2) @(negedge clk);
    check("done_fall_run", out_done, 0);
    host_req(0, MAT_C, 2'd0, 64'h00000003_00000002, 4, "hrd_c0");
    host_req(0, MAT_C, 2'd1, 64'h00000005_00000004, 4, "hrd_c1");

    // Host and start together: host wins; then a host request during RUN waits for IDLE.
    fork
      host_req(0, MAT_C, 2'd1, 64'h00000005_00000004, 4, "arb_host_first");
      begin @(posedge clk); #1; in_start = 1; end
    join
    wait_sig("arb_run", 0);
    h0 = hack_cnt;
    fork
      host_req(0, MAT_B, 2'd0, B0, 0, "arb_held");
      begin
        repeat (6) @(negedge clk);
        check("no_ack_in_run", hack_cnt - h0, 0);
        @(posedge clk); #1; in_cop_ready = 1;
        wait_sig("arb_done", 1);
        @(posedge clk); #1; in_cop_ready = 0;
        repeat (3) @(negedge clk);
        check("no_ack_in_done", hack_cnt - h0, 0);
        @(posedge clk); #1; in_start = 0;
      end
    join
    check("arb_ack_after_done", hack_cnt - h0, 1);

    // Read and write together: read first, then write, each exactly once.
    @(posedge clk); #1; in_start = 1;
    wait_sig("rw_run", 0);
    rd0 = rd_cnt; wr0 = wr_cnt; dr0 = dr_cnt; ca0 = cack_cnt;
    @(posedge clk); #1;
    in_cop_read_en = 1; in_cop_write_en = 1; in_cop_matrix = MAT_C; in_cop_address = 2'd3;
    in_cop_type = TYPE_ROW; in_cop_data = 64'h0badf00d_00c0ffee;
    cop_q.push_back(64'h0);
    got_dr = 0; got_ack = 0; order_ok = 0; n = 0;
    while (!(got_dr && got_ack) && n < 40) begin
      @(negedge clk); n++;
      if (out_cop_data_ready) begin got_dr = 1; order_ok = !got_ack; end
      if (out_cop_ack) got_ack = 1;
      @(posedge clk); #1;
      if (got_dr) in_cop_read_en = 0;
      if (got_ack) in_cop_write_en = 0;
    end
    in_cop_read_en = 0; in_cop_write_en = 0;
    repeat (4) @(negedge clk);
    check("rw_read_first", order_ok, 1);
    check("rw_rf_reads", rd_cnt - rd0, 1);
    check("rw_rf_writes", wr_cnt - wr0, 1);
    check("rw_data_ready", dr_cnt - dr0, 1);
    check("rw_cop_ack", cack_cnt - ca0, 1);

    // Read held for six cycles: two services separated by the ignore cycle.
    rd0 = rd_cnt; dr0 = dr_cnt;
    cop_q.push_back(A2);
    cop_q.push_back(A2);
    @(posedge clk); #1;
    in_cop_read_en = 1; in_cop_matrix = MAT_A; in_cop_address = 2'd2; in_cop_type = TYPE_ROW;
    repeat (6) @(negedge clk);
    @(posedge clk); #1; in_cop_read_en = 0;
    repeat (8) @(negedge clk);
    check("b2b_rf_reads", rd_cnt - rd0, 2);
    check("b2b_data_ready", dr_cnt - dr0, 2);
    check("b2b_gap", dr_gap, 4);
    finish_run();
    host_req(0, MAT_C, 2'd3, 64'h0badf00d_00c0ffee, 4, "hrd_c3");

    repeat (3) @(negedge clk);
    check("sb_host_empty", host_q.size(), 0);
    check("sb_cop_empty", cop_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
